// File: rtl/fire_fifo_if.sv
// Handshake bundle between the neuron-update stage (master) and the fire FIFO (slave).
// Carries push/pop strobes, the tag path and the full/empty flow-control flags.
interface fire_fifo_if #(
  parameter int TAG_WIDTH = 1
);
  logic                 enq;
  logic                 deq;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 full;
  logic                 empty;

  modport master (
    output enq,
    output deq,
    output in_tag,
    input  out_tag,
    input  full,
    input  empty
  );

  modport slave (
    input  enq,
    input  deq,
    input  in_tag,
    output out_tag,
    output full,
    output empty
  );
endinterface

// File: rtl/fire_fifo.sv
// First-word fall-through FIFO of fired-neuron tags; the head entry is presented
// combinationally and the flags decode from an occupancy counter.
module fire_fifo #(
  parameter int TAG_WIDTH = 1,
  parameter int DEPTH     = 4
) (
  input  logic         clk,
  input  logic         asyn_reset,
  fire_fifo_if.slave   bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [TAG_WIDTH-1:0]  storage_q [DEPTH];
  logic [TAG_WIDTH-1:0]  storage_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic full;
  logic empty;
  logic acc_enq;
  logic acc_deq;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // A push into a full FIFO is still taken when a pop frees the head slot in the same edge.
  assign acc_enq = bus.enq & (~full | bus.deq);
  assign acc_deq = bus.deq & ~empty;

  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (acc_enq) begin
      storage_d[wr_ptr_q] = bus.in_tag;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (acc_deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (acc_enq && !acc_deq) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (acc_deq && !acc_enq) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      storage_q <= storage_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.out_tag = empty ? '0 : storage_q[rd_ptr_q];
endmodule

// File: tb/tb_fire_fifo.sv
// Scoreboard bench for fire_fifo: expected tags are queued on accepted pushes and
// compared against out_tag on accepted pops; flags and head are checked every cycle.
module tb_fire_fifo;
  localparam int TAG_WIDTH = 1;
  localparam int DEPTH     = 4;

  logic clk;
  logic asyn_reset;

  fire_fifo_if #(.TAG_WIDTH(TAG_WIDTH)) bus ();

  fire_fifo #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [TAG_WIDTH-1:0] model_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_state(input string name);
    logic [31:0] exp_head;
    exp_head = (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0;
    check({name, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check({name, "_full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
    check({name, "_head"},  32'(bus.out_tag), exp_head);
  endtask

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input string name, input logic e, input logic d, input logic [TAG_WIDTH-1:0] t);
    logic acc_e;
    logic acc_d;
    logic [TAG_WIDTH-1:0] exp_tag;
    bus.enq    = e;
    bus.deq    = d;
    bus.in_tag = t;
    acc_d = d && (model_q.size() != 0);
    acc_e = e && ((model_q.size() != DEPTH) || d);
    if (acc_d) begin
      exp_tag = model_q.pop_front();
      check({name, "_pop"}, 32'(bus.out_tag), 32'(exp_tag));
    end
    @(posedge clk);
    #1;
    if (acc_e) model_q.push_back(t);
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    $display("%s enq=%0b deq=%0b tag=%0h -> empty=%0b full=%0b out=%0h", name, e, d, t,
             bus.empty, bus.full, bus.out_tag);
    check_state(name);
  endtask

  // Reset is raised between edges and checked before any further edge.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #1;
    asyn_reset = 1'b1;
    #1;
    model_q.delete();
    check_state(name);
    @(negedge clk);
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
    check_state({name, "_rel"});
  endtask

  initial begin
    asyn_reset = 1'b0;
    bus.enq    = 1'b0;
    bus.deq    = 1'b0;
    bus.in_tag = '0;

    // Reset with no clock edge yet.
    #2;
    asyn_reset = 1'b1;
    #1;
    check_state("rst_noclk");
    // Push/pop requests while in reset must be ignored.
    bus.enq    = 1'b1;
    bus.deq    = 1'b1;
    bus.in_tag = 1'b1;
    @(posedge clk);
    #1;
    check_state("rst_hold");
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    @(negedge clk);
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;

    // Two zero tags in, two out.
    step("t2_enq0", 1, 0, 0);
    step("t2_enq1", 1, 0, 0);
    step("t2_deq0", 0, 1, 0);
    step("t2_deq1", 0, 1, 0);

    // Fill, overflow drop, drain.
    step("t3_enq_a", 1, 0, 1);
    step("t3_enq_b", 1, 0, 0);
    step("t3_enq_c", 1, 0, 1);
    step("t3_enq_d", 1, 0, 1);
    step("t3_drop",  1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("t3_drain", 0, 1, 0);

    // Pointer wrap.
    step("t4_enq", 1, 0, 1);
    step("t4_enq", 1, 0, 0);
    step("t4_enq", 1, 0, 1);
    for (int i = 0; i < 3; i++) step("t4_deq", 0, 1, 0);
    step("t4_fill", 1, 0, 1);
    step("t4_fill", 1, 0, 1);
    step("t4_fill", 1, 0, 0);
    step("t4_fill", 1, 0, 1);
    for (int i = 0; i < DEPTH; i++) step("t4_drain", 0, 1, 0);

    // Simultaneous push/pop at the boundaries.
    step("t5_both_empty", 1, 1, 1);
    step("t5_fill", 1, 0, 1);
    step("t5_fill", 1, 0, 0);
    step("t5_fill", 1, 0, 1);
    step("t5_both_full", 1, 1, 0);
    step("t5_both_mid_pre", 0, 1, 0);
    step("t5_both_mid", 1, 1, 1);
    for (int i = 0; i < DEPTH; i++) step("t5_drain", 0, 1, 0);
    step("t5_deq_empty", 0, 1, 0);

    // Reset mid-operation with three entries held.
    step("t6_enq", 1, 0, 1);
    step("t6_enq", 1, 0, 1);
    step("t6_enq", 1, 0, 0);
    mid_reset("t6_rst");
    step("t6_after_enq", 1, 0, 1);
    step("t6_after_deq", 0, 1, 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 80; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_WIDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule
